outbus_sampler: RTL and testbench
=================================

# outbus_sampler

Change-capture stage that sits directly downstream of the 5-bit connector output bus. Each cycle it compares the bus against its previous value. Every change is queued as an entry in a small FIFO and drained through a valid/ready port. It also keeps a saturating change counter and a sticky overflow flag, so the bench and lab logic can observe bus activity without sampling every cycle.

## Interface
- DEPTH, 8: number of FIFO entries; power of two, ≥ 2.
- TS_W, 8: timestamp width in bits; used only when the timestamp feature is compiled in.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- inBus  input  5  monitored bus; driven by the upstream connector's outBus.
- enable  input  1  when high, detected changes are counted and queued.
- clear  input  1  synchronous flush of FIFO, counter and overflow flag.
- out_valid  output  1  FIFO head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  5  bus value of the head entry; 0 when out_valid is low.
- out_ts  output  TS_W  timestamp of the head entry; 0 when out_valid is low; present only with the macro.
- change_cnt  output  16  number of detected changes; saturates at 16'hFFFF.
- overflow  output  1  sticky; a change was dropped because the FIFO was full.

## Operation
- prev_q is a 5-bit register that loads inBus on every edge, regardless of enable or clear. Because it always tracks the bus, enabling detection never produces a spurious change.
- Change condition: `enable && !clear && (inBus != prev_q)`.
- Timestamp counter: TS_W bits, free-running, increments every cycle after reset, wraps to 0. It is not affected by clear.
- On a change:
  - change_cnt increments, saturating at 16'hFFFF.
  - The entry {inBus, ts} is pushed if the FIFO has space after this cycle's pop.
  - Otherwise the entry is dropped and overflow is set.
- Pop: `out_valid && out_ready` removes the head entry.
- Occupancy, count 0..DEPTH:
  - EMPTY: out_valid is 0.
  - PARTIAL: out_valid is 1.
  - FULL: out_valid is 1, and a push without a pop is dropped.
- Push and pop in the same cycle when FULL: both are accepted, the count is unchanged, and overflow is not set.
- Push and pop in the same cycle when EMPTY: a pop is impossible because out_valid is 0, so only the push takes effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- While out_valid is high and out_ready is low, out_data and out_ts hold stable.
- clear:
  - Empties the FIFO.
  - Zeroes change_cnt.
  - Clears overflow.
  - A change in the same cycle is neither counted nor queued, and a pop in that cycle is a no-op.
- Reset values:
  - Outputs: out_valid 0, out_data 0, out_ts 0, change_cnt 0, overflow 0.
  - Internal: prev_q 0, ts 0, pointers 0, count 0.
- First enabled cycle after reset: prev_q is 0, so any nonzero inBus counts as a change.
- Reset asserted mid-operation: all queued entries are lost, and all outputs return to their reset values asynchronously.

## Timing
- Change-to-output latency: inBus differs from prev_q before edge k, the entry is pushed at edge k, and out_valid is high after edge k when the FIFO was empty.
- The timestamp stored in an entry is the ts value before edge k.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry, if any, is visible after that same edge, giving a sustained throughput of one entry per cycle.
- change_cnt and overflow update at the same edge as the detection.
- overflow is high after the edge where the first drop occurs.
- No combinational path exists from out_ready to out_valid, out_data or out_ts.

## Configuration
- OUTBUS_SAMPLER_TSTAMP_EN defined:
  - The timestamp counter is built.
  - The out_ts port exists.
  - FIFO entries are 5+TS_W bits.
- OUTBUS_SAMPLER_TSTAMP_EN undefined:
  - No timestamp counter and no out_ts port.
  - FIFO entries are 5 bits; TS_W is ignored.
  - All other behaviour is identical.

## Test plan
- Reset then enable: reset low then released, enable=1, inBus=5'h00 held for 10 cycles -> out_valid 0, change_cnt 0; then inBus=5'h15 -> out_valid=1 and out_data=5'h15 one edge later, change_cnt=1.
- Ordering and backpressure: out_ready=0, inBus changes on consecutive cycles through 5'h01, 5'h02, 5'h03 -> out_data stays 5'h01 while stalled; out_ready=1 -> entries drain as 01, 02, 03 on successive cycles, then out_valid 0.
- Overflow (DEPTH=8): out_ready=0, 9 distinct consecutive changes -> count 8, overflow=1, change_cnt=9, drained entries are the first 8; then clear=1 -> out_valid 0, change_cnt 0, overflow 0.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and a change on the same cycle -> count stays 8, overflow stays 0, the new entry appears last.
- Enable gating and clear priority: enable=0 while inBus toggles, then enable=1 with inBus held -> no entries; a change coincident with clear=1 -> not queued, change_cnt 0.
- Timestamp (macro defined, TS_W=8): changes at ts=8'hFE and at 8'h03 after wrap -> out_ts reads 8'hFE then 8'h03; reset asserted mid-drain -> out_valid drops to 0 immediately.

Source files
------------

// File: rtl/outbus_sampler.sv
`default_nettype none
// ============================================================================
// Module   : outbus_sampler
// Purpose  : Change-capture stage for the 5-bit connector bus. Every bus change
//            is counted and queued in a FIFO drained through a valid/ready port.
//            Optional timestamps: define OUTBUS_SAMPLER_TSTAMP_EN.
// Revision : 1.0  initial release
// ============================================================================
module outbus_sampler #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       inBus,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data,
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
  output logic [TS_W-1:0]  out_ts,
`endif
  output logic [15:0]      change_cnt,
  output logic             overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
  localparam int c_ENT_W = 5 + TS_W;
`else
  // TS_W contributes nothing here; the term keeps the parameter referenced.
  localparam int c_ENT_W = 5 + 0 * TS_W;
`endif
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [15:0]        c_CNT_MAX = 16'hFFFF;

  logic [4:0]         r_prev;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [15:0]        r_chg_cnt;
  logic               r_ovf;
  logic [c_ENT_W-1:0] r_mem [DEPTH];

  logic               w_change;
  logic               w_pop;
  logic               w_space;
  logic               w_push;
  logic               w_drop;
  logic [c_ENT_W-1:0] w_entry;
  logic [c_ENT_W-1:0] w_head;

`ifdef OUTBUS_SAMPLER_TSTAMP_EN
  logic [TS_W-1:0] r_ts;

  // Free-running; deliberately unaffected by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_entry = {inBus, r_ts};
`else
  assign w_entry = inBus;
`endif

  // prev always tracks the bus so enabling detection never sees a stale value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= '0;
    else        r_prev <= inBus;
  end

  assign w_change = enable && !clear && (inBus != r_prev);
  assign w_pop    = out_valid && out_ready && !clear;
  // Space is judged after this cycle's pop, so full + pop + push is accepted.
  assign w_space  = (r_count != c_FULL) || w_pop;
  assign w_push   = w_change && w_space;
  assign w_drop   = w_change && !w_space;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chg_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (clear) begin
      r_chg_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_change && (r_chg_cnt != c_CNT_MAX)) r_chg_cnt <= r_chg_cnt + 16'd1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Outputs depend only on registered state: no path from out_ready.
  assign w_head     = r_mem[r_rptr];
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? w_head[c_ENT_W-1 -: 5] : 5'd0;
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
  assign out_ts     = out_valid ? w_head[TS_W-1:0] : '0;
`endif
  assign change_cnt = r_chg_cnt;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_outbus_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_outbus_sampler
// Purpose  : Self-checking bench for outbus_sampler against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_outbus_sampler;
  localparam int DEPTH = 8;
  localparam int TS_W  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [4:0]      inBus = 5'd0;
  logic            enable = 1'b0;
  logic            clear = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [4:0]      out_data;
  logic [TS_W-1:0] out_ts;
  logic [15:0]     change_cnt;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]      d;
    logic [TS_W-1:0] t;
  } ent_t;

  ent_t            mq[$];
  int              m_cnt;
  bit              m_ovf;
  logic [4:0]      m_prev;
  logic [TS_W-1:0] m_ts;

  always #5 clk = ~clk;

  outbus_sampler #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .inBus      (inBus),
    .enable     (enable),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
    .out_ts     (out_ts),
`endif
    .change_cnt (change_cnt),
    .overflow   (overflow)
  );

`ifndef OUTBUS_SAMPLER_TSTAMP_EN
  assign out_ts = '0;
`endif

  task automatic model_reset();
    mq.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 5'd0;
    m_ts   = '0;
  endtask

  // Advance the model by one cycle using current inputs, then clock the DUT.
  task automatic step();
    bit   pop;
    bit   chg;
    ent_t e;
    pop = (mq.size() != 0) && out_ready && !clear;
    chg = enable && !clear && (inBus != m_prev);
    if (clear) begin
      mq.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (chg) begin
        if (m_cnt < 65535) m_cnt++;
        if (mq.size() < DEPTH) begin
          e.d = inBus;
          e.t = m_ts;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_prev = inBus;
    m_ts   = m_ts + TS_W'(1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] exp_data();
    return (mq.size() != 0) ? mq[0].d : 5'd0;
  endfunction

  function automatic logic [TS_W-1:0] exp_ts();
    return (mq.size() != 0) ? mq[0].t : '0;
  endfunction

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 5'd0) begin bad++; $display("FAIL rst_data: got %h want 00", out_data); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", change_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_enable_first();
    enable = 1'b1;
    inBus  = 5'h00;
    repeat (10) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL idle_cnt: got %0d want 0", change_cnt); end
    inBus = 5'h15;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 5'h15) begin bad++; $display("FAIL first_data: got %h want 15", out_data); end
    total++; if (change_cnt !== 16'd1) begin bad++; $display("FAIL first_cnt: got %0d want 1", change_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    inBus = 5'h01; step();
    inBus = 5'h02; step();
    total++; if (out_data !== 5'h01) begin bad++; $display("FAIL bp_hold1: got %h want 01", out_data); end
    inBus = 5'h03; step();
    total++; if (out_data !== 5'h01) begin bad++; $display("FAIL bp_hold2: got %h want 01", out_data); end
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 5'h02) begin bad++; $display("FAIL bp_drain2: got %h want 02", out_data); end
    step();
    total++; if (out_data !== 5'h03) begin bad++; $display("FAIL bp_drain3: got %h want 03", out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    total++; if (change_cnt !== 16'd4) begin bad++; $display("FAIL bp_cnt: got %0d want 4", change_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL ov_preclear: got %0d want 0", change_cnt); end
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      inBus = 5'(5'h10 + i);
      step();
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_flag: got %b want 1", overflow); end
    total++; if (change_cnt !== 16'd9) begin bad++; $display("FAIL ov_cnt: got %0d want 9", change_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 5'(5'h10 + i)) begin
        bad++; $display("FAIL ov_order[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 5'(5'h10 + i));
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ov_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
    inBus = 5'h07; step();
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", change_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    logic [4:0] exp_q[$];
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      inBus = 5'(i);
      exp_q.push_back(5'(i));
      step();
    end
    out_ready = 1'b1;
    inBus = 5'h1F;
    step();
    void'(exp_q.pop_front());
    exp_q.push_back(5'h1F);
    out_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
    total++; if (change_cnt !== 16'd9) begin bad++; $display("FAIL fpp_cnt: got %0d want 9", change_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        bad++; $display("FAIL fpp_order[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_q[i]);
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_enable_clear();
    clear = 1'b1; step(); clear = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inBus = inBus ^ 5'(1 + (i % 31));
      step();
    end
    enable = 1'b1;
    repeat (5) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gate_valid: got %b want 0", out_valid); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL gate_cnt: got %0d want 0", change_cnt); end
    clear = 1'b1;
    inBus = inBus ^ 5'h0C;
    step();
    clear = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clrpri_valid: got %b want 0", out_valid); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL clrpri_cnt: got %0d want 0", change_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) inBus = 5'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      out_ready = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      step();
      total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, mq.size() != 0); end
      total++; if (out_data !== exp_data()) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, exp_data()); end
      total++; if (change_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, change_cnt, m_cnt); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, m_ovf); end
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
      total++; if (out_ts !== exp_ts()) begin bad++; $display("FAIL rnd_ts@%0d: got %h want %h", i, out_ts, exp_ts()); end
`endif
    end
    clear = 1'b0;
    enable = 1'b1;
    out_ready = 1'b0;
  endtask

`ifdef OUTBUS_SAMPLER_TSTAMP_EN
  task automatic test_timestamp();
    int guard;
    enable = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b0;
    guard = 0;
    while (m_ts != 8'hFE && guard < 300) begin step(); guard++; end
    inBus = m_prev ^ 5'h0A;
    step();
    guard = 0;
    while (m_ts != 8'h03 && guard < 300) begin step(); guard++; end
    inBus = inBus ^ 5'h01;
    step();
    total++; if (out_ts !== 8'hFE) begin bad++; $display("FAIL ts_first: got %h want fe", out_ts); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (out_ts !== 8'h03) begin bad++; $display("FAIL ts_wrap: got %h want 03", out_ts); end
  endtask
`endif

  task automatic test_async_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inBus = inBus ^ 5'(i + 1);
      step();
    end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre: got %b want 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 5'd0) begin bad++; $display("FAIL ar_data: got %h want 00", out_data); end
    total++; if (change_cnt !== 16'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", change_cnt); end
    total++; if (out_ts !== '0) begin bad++; $display("FAIL ar_ts: got %h want 00", out_ts); end
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    step();
    total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL ar_after: got %b want %b", out_valid, mq.size() != 0); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_enable_first();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_enable_clear();
    test_random();
`ifdef OUTBUS_SAMPLER_TSTAMP_EN
    test_timestamp();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
